// File: rtl/uart_reg_pkg.sv
// -----------------------------------------------------------------------------
// uart_reg_pkg
// Shared constants and types for the UART register-bus command controller.
//   OP_WR / OP_RD     : host opcodes ('W' = write frame, 'R' = read frame)
//   RSP_ACK / RSP_NAK : response bytes ('K' = write done, '?' = unknown opcode)
//   state_t           : controller state encoding
// -----------------------------------------------------------------------------
package uart_reg_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_NAK = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REG_WR,
        ST_REG_RD,
        ST_RD_CAP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

endpackage

// File: rtl/uart_reg_timer.sv
// -----------------------------------------------------------------------------
// uart_reg_timer
// Saturating inter-byte gap counter.
//   clk      in  system clock
//   rstb     in  synchronous active-low reset (counter -> 0)
//   clear    in  reload the counter with zero (has priority over enable)
//   enable   in  count one cycle of gap
//   expired  out counter has reached TIMEOUT_CYC
// The counter stops at TIMEOUT_CYC so a long stall never wraps back into the
// "still alive" range.
// -----------------------------------------------------------------------------
module uart_reg_timer #(
    parameter int unsigned TIMEOUT_CYC = 434000
) (
    input  logic clk,
    input  logic rstb,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && (cnt_reg != LIMIT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = (cnt_reg == LIMIT);

endmodule

// File: rtl/uart_reg_ctrl.sv
// -----------------------------------------------------------------------------
// uart_reg_ctrl
// Parses host command frames from the UART receive byte stream, drives a
// byte-wide register bus and returns one response byte through the UART
// transmitter.
//   clk        in  system clock
//   rstb       in  synchronous active-low reset
//   rx_valid   in  one-cycle pulse, rx_data holds a received byte
//   rx_data    in  received byte
//   wr_en      out one-cycle launch pulse to the transmitter
//   wr_data    out byte to transmit (holds the last response)
//   tx_busy    in  transmitter busy
//   reg_addr   out register address (holds between frames)
//   reg_wdata  out register write data (holds between frames)
//   reg_wr     out one-cycle write strobe
//   reg_rd     out one-cycle read strobe
//   reg_rdata  in  register read data, valid the cycle after reg_rd
//   busy       out high whenever the controller is not idle
//   err        out one-cycle pulse: timeout, bad opcode, or byte dropped
//                  while a response is being produced
// Frames: 'W' addr data -> 'K'; 'R' addr -> register byte; other -> '?'.
// -----------------------------------------------------------------------------
module uart_reg_ctrl
    import uart_reg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 434000
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [7:0] wr_data,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err
);

    state_t     state_reg, state_next;
    logic       is_wr_reg, is_wr_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [7:0] rsp_reg, rsp_next;
    logic       err_reg, err_next;
    logic       first_reg, first_next;   // first cycle of WAIT_TX

    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;

    // Gap timer only runs while a frame is partially received; any received
    // byte restarts it, and idling keeps it parked at zero.
    assign timer_clear  = rx_valid || (state_reg == ST_IDLE);
    assign timer_enable = (state_reg == ST_ADDR) || (state_reg == ST_DATA);

    uart_reg_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rstb    (rstb),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_reg <= ST_IDLE;
            is_wr_reg <= 1'b0;
            addr_reg  <= 8'h00;
            wdata_reg <= 8'h00;
            rsp_reg   <= 8'h00;
            err_reg   <= 1'b0;
            first_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            is_wr_reg <= is_wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rsp_reg   <= rsp_next;
            err_reg   <= err_next;
            first_reg <= first_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        is_wr_next = is_wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rsp_next   = rsp_reg;
        err_next   = 1'b0;
        first_next = first_reg;

        case (state_reg)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR) begin
                        is_wr_next = 1'b1;
                        state_next = ST_ADDR;
                    end else if (rx_data == OP_RD) begin
                        is_wr_next = 1'b0;
                        state_next = ST_ADDR;
                    end else begin
                        rsp_next   = RSP_NAK;
                        err_next   = 1'b1;
                        state_next = ST_SEND;
                    end
                end
            end
            // Timeout wins over a byte arriving in the same cycle: a gap of
            // TIMEOUT_CYC idle cycles is already too long.
            ST_ADDR: begin
                if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    addr_next  = rx_data;
                    state_next = is_wr_reg ? ST_DATA : ST_REG_RD;
                end
            end
            ST_DATA: begin
                if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    wdata_next = rx_data;
                    state_next = ST_REG_WR;
                end
            end
            ST_REG_WR: begin
                rsp_next   = RSP_ACK;
                state_next = ST_SEND;
            end
            ST_REG_RD: begin
                state_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rsp_next   = reg_rdata;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    first_next = 1'b1;
                    state_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                // tx_busy may still be low in the cycle right after wr_en,
                // so it is only trusted from the second cycle on.
                if (first_reg) begin
                    first_next = 1'b0;
                end else if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Bytes arriving while a response is being produced are dropped.
        if (rx_valid && (state_reg inside {ST_REG_WR, ST_REG_RD, ST_RD_CAP,
                                           ST_SEND, ST_WAIT_TX})) begin
            err_next = 1'b1;
        end
    end

    assign reg_wr    = (state_reg == ST_REG_WR);
    assign reg_rd    = (state_reg == ST_REG_RD);
    assign wr_en     = (state_reg == ST_SEND) && !tx_busy;
    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;
    assign wr_data   = rsp_reg;
    assign reg_addr  = addr_reg;
    assign reg_wdata = wdata_reg;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_ctrl
// Self-checking bench for uart_reg_ctrl (TIMEOUT_CYC = 100). Expected register
// strobes, transmitter launches and err pulses are queued, with the cycle they
// must appear in, when stimulus is driven; a scoreboard task pops and compares
// them as the DUT produces them. A register-file model answers reads and a
// transmitter model raises tx_busy for a few cycles after each wr_en.
// -----------------------------------------------------------------------------
module tb_uart_reg_ctrl;

    localparam int unsigned TO     = 100;
    localparam int          TX_LEN = 8;

    logic       clk;
    logic       rstb;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err;

    logic       tx_hold;
    int         tx_cnt;
    int         cyc;
    int         checks;
    int         errors;

    bit [7:0]   mem [256];
    bit         mem_wr [256];
    bit [7:0]   shadow [256];
    bit         sh_wr [256];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    ev_t exp_wr[$];
    ev_t exp_rd[$];
    ev_t exp_tx[$];
    ev_t exp_err[$];

    uart_reg_ctrl #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .tx_busy   (tx_busy),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for TX_LEN cycles after a launch, or held by the bench.
    always @(posedge clk) begin
        if (wr_en === 1'b1) tx_cnt <= TX_LEN;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0) || tx_hold;

    // Register-file model: unwritten locations read as addr ^ 0x1E; data is
    // only meaningful the cycle after reg_rd.
    always @(posedge clk) begin
        if (reg_wr === 1'b1) begin
            mem[reg_addr]    <= reg_wdata;
            mem_wr[reg_addr] <= 1'b1;
        end
        if (reg_rd === 1'b1) reg_rdata <= mem_wr[reg_addr] ? mem[reg_addr] : (reg_addr ^ 8'h1E);
        else                 reg_rdata <= 8'hEE;
    end

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return sh_wr[a] ? shadow[a] : (a ^ 8'h1E);
    endfunction

    // ---------------------------------------------------------------- stimulus
    task automatic send_byte(input logic [7:0] b, output int c);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        c        = cyc;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int c;
        send_byte(8'h57, c);
        send_byte(a, c);
        send_byte(d, c);
        exp_wr.push_back('{a, d, c + 1});
        exp_tx.push_back('{8'h00, 8'h4B, c + 2});
        shadow[a] = d;
        sh_wr[a]  = 1'b1;
    endtask

    task automatic do_read(input logic [7:0] a);
        int c;
        send_byte(8'h52, c);
        send_byte(a, c);
        exp_rd.push_back('{a, 8'h00, c + 1});
        exp_tx.push_back('{8'h00, model_rd(a), c + 3});
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while ((busy !== 1'b0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
                exp_tx.size() != 0 || exp_err.size() != 0) && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
            exp_tx.size() != 0 || exp_err.size() != 0) begin
            errors++;
            $display("FAIL %s_done: busy=%b pending wr=%0d rd=%0d tx=%0d err=%0d after %0d cycles, required idle with nothing pending",
                     name, busy, exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_err.size(), n);
        end
    endtask

    // -------------------------------------------------------------- scoreboard
    task automatic scoreboard();
        logic [3:0] prev;
        logic [3:0] cur;
        ev_t        e;
        prev = 4'b0;
        forever begin
            @(negedge clk);
            cur = {reg_wr === 1'b1, reg_rd === 1'b1, wr_en === 1'b1, err === 1'b1};
            if (rstb !== 1'b1) begin
                prev = 4'b0;
                continue;
            end
            if (cur != 4'b0) begin
                checks++;
                if ((cur & prev) != 4'b0) begin
                    errors++;
                    $display("FAIL pulse_width: {reg_wr,reg_rd,wr_en,err} high two cycles in a row (%b) at cycle %0d, required single-cycle pulses",
                             cur & prev, cyc);
                end
            end
            if (cur[3]) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL reg_wr_unexpected: addr=%02h data=%02h at cycle %0d, required no strobe", reg_addr, reg_wdata, cyc);
                end else begin
                    e = exp_wr.pop_front();
                    if (reg_addr !== e.a || reg_wdata !== e.d || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL reg_wr: addr=%02h data=%02h cycle %0d, required addr=%02h data=%02h cycle %0d",
                                 reg_addr, reg_wdata, cyc, e.a, e.d, e.cyc);
                    end else $display("reg_wr addr=%02h data=%02h cycle %0d", reg_addr, reg_wdata, cyc);
                end
            end
            if (cur[2]) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL reg_rd_unexpected: addr=%02h at cycle %0d, required no strobe", reg_addr, cyc);
                end else begin
                    e = exp_rd.pop_front();
                    if (reg_addr !== e.a || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL reg_rd: addr=%02h cycle %0d, required addr=%02h cycle %0d", reg_addr, cyc, e.a, e.cyc);
                    end else $display("reg_rd addr=%02h cycle %0d", reg_addr, cyc);
                end
            end
            if (cur[1]) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL wr_en_unexpected: wr_data=%02h at cycle %0d, required no launch", wr_data, cyc);
                end else begin
                    e = exp_tx.pop_front();
                    if (wr_data !== e.d || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL wr_en: wr_data=%02h cycle %0d, required wr_data=%02h cycle %0d", wr_data, cyc, e.d, e.cyc);
                    end else $display("tx byte=%02h cycle %0d", wr_data, cyc);
                end
            end
            if (cur[0]) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: err pulse at cycle %0d, required none", cyc);
                end else begin
                    e = exp_err.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL err: pulse at cycle %0d, required cycle %0d", cyc, e.cyc);
                    end else $display("err cycle %0d", cyc);
                end
            end
            prev = cur;
        end
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err} !== 29'h0) begin
            errors++;
            $display("FAIL reset_values: wr_en=%b wr_data=%02h addr=%02h wdata=%02h reg_wr=%b reg_rd=%b busy=%b err=%b, required all zero",
                     wr_en, wr_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err);
        end
        @(posedge clk); #1;
        rstb = 1'b1;
    endtask

    task automatic test_write();
        do_write(8'h10, 8'hA5);
        wait_done("write", 200);
        checks++;
        if (reg_addr !== 8'h10 || reg_wdata !== 8'hA5 || wr_data !== 8'h4B) begin
            errors++;
            $display("FAIL write_hold: addr=%02h wdata=%02h wr_data=%02h, required 10 A5 4B", reg_addr, reg_wdata, wr_data);
        end
    endtask

    task automatic test_read();
        do_read(8'h22);
        wait_done("read_22", 200);
        do_read(8'h10);
        wait_done("read_10", 200);
    endtask

    task automatic test_bad_opcode();
        int c;
        send_byte(8'h41, c);
        exp_err.push_back('{8'h00, 8'h00, c + 1});
        exp_tx.push_back('{8'h00, 8'h3F, c + 1});
        wait_done("bad_opcode", 200);
    endtask

    task automatic test_timeout();
        int c;
        // Stall in DATA: abort decided when the gap reaches TO, visible one cycle later.
        send_byte(8'h57, c);
        send_byte(8'h10, c);
        exp_err.push_back('{8'h00, 8'h00, c + int'(TO) + 2});
        wait_done("timeout_data", 300);
        // Stall in ADDR.
        send_byte(8'h52, c);
        exp_err.push_back('{8'h00, 8'h00, c + int'(TO) + 2});
        wait_done("timeout_addr", 300);
        // Normal read afterwards.
        do_read(8'h10);
        wait_done("after_timeout", 200);
        // Byte arriving after exactly TO idle cycles is too late and is lost.
        send_byte(8'h57, c);
        send_byte(8'h10, c);
        repeat (TO - 1) @(posedge clk);
        send_byte(8'hA5, c);
        exp_err.push_back('{8'h00, 8'h00, c + 1});
        wait_done("gap_eq_timeout", 300);
        // TO-1 idle cycles is still accepted.
        send_byte(8'h57, c);
        send_byte(8'h10, c);
        repeat (TO - 2) @(posedge clk);
        send_byte(8'h5A, c);
        exp_wr.push_back('{8'h10, 8'h5A, c + 1});
        exp_tx.push_back('{8'h00, 8'h4B, c + 2});
        shadow[8'h10] = 8'h5A;
        sh_wr[8'h10]  = 1'b1;
        wait_done("gap_below_timeout", 300);
        do_read(8'h10);
        wait_done("read_after_gap", 200);
    endtask

    task automatic test_busy_hold();
        int c;
        int ci;
        tx_hold = 1'b1;
        send_byte(8'h57, c);
        send_byte(8'h33, c);
        send_byte(8'h77, c);
        exp_wr.push_back('{8'h33, 8'h77, c + 1});
        shadow[8'h33] = 8'h77;
        sh_wr[8'h33]  = 1'b1;
        repeat (18) @(posedge clk);
        send_byte(8'h55, ci);                       // dropped while in SEND
        exp_err.push_back('{8'h00, 8'h00, ci + 1});
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_data !== 8'h4B) begin
            errors++;
            $display("FAIL hold_send: busy=%b wr_data=%02h, required busy=1 wr_data=4B", busy, wr_data);
        end
        @(posedge clk); #1;
        tx_hold = 1'b0;
        exp_tx.push_back('{8'h00, 8'h4B, cyc});
        send_byte(8'h52, ci);                       // dropped while in WAIT_TX
        exp_err.push_back('{8'h00, 8'h00, ci + 1});
        wait_done("busy_hold", 200);
        checks++;
        if (wr_data !== 8'h4B || reg_addr !== 8'h33) begin
            errors++;
            $display("FAIL hold_response: wr_data=%02h addr=%02h, required 4B 33", wr_data, reg_addr);
        end
        do_read(8'h33);
        wait_done("read_after_hold", 200);
    endtask

    task automatic test_reset_mid_frame();
        int c;
        send_byte(8'h57, c);
        send_byte(8'h44, c);                        // now waiting for data
        rstb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err} !== 29'h0) begin
            errors++;
            $display("FAIL reset_mid_frame: wr_en=%b wr_data=%02h addr=%02h wdata=%02h reg_wr=%b reg_rd=%b busy=%b err=%b, required all zero",
                     wr_en, wr_data, reg_addr, reg_wdata, reg_wr, reg_rd, busy, err);
        end
        @(posedge clk); #1;
        rstb = 1'b1;
        do_write(8'h44, 8'h99);
        wait_done("write_after_reset", 200);
        do_read(8'h44);
        wait_done("read_after_reset", 200);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d);
                wait_done("b2b_write", 200);
            end
            do_read(a);
            wait_done("b2b_read", 200);
        end
    endtask

    initial begin
        rstb     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_hold  = 1'b0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_busy_hold();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 || exp_err.size() != 0) begin
            errors++;
            $display("FAIL final_queues: pending wr=%0d rd=%0d tx=%0d err=%0d, required all empty",
                     exp_wr.size(), exp_rd.size(), exp_tx.size(), exp_err.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
